// File: rtl/mem_stage.sv
// Memory stage: pass-through for non-memory ops, single outstanding load/store on dmem valid/ready.
// Latency: ALU ops 1 cycle, stores >=2, loads >=3 (TIMEOUT_CYCLES aborts a silent load, 0 disables).
// Backpressure: stall_o high whenever not IDLE; TARTARUGA_MEM_MISALIGN_TRAP_EN traps misaligned H/W.
package mem_stage_pkg;
    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_kind_e;
    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} mem_size_e;

    typedef struct packed {
        mem_kind_e  mem_kind;
        mem_size_e  mem_size;
        logic       mem_unsigned;
        logic [4:0] addr_rd;
    } instr_t;

    typedef struct packed {
        logic        valid;
        instr_t      instr;
        logic [31:0] result;
        logic [31:0] data_rs2;
        logic        branch_taken;
    } exe_to_mem_t;

    typedef struct packed {
        logic        valid;
        instr_t      instr;
        logic [31:0] result;
        logic        branch_taken;
        logic        xcpt;
    } mem_to_wb_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  exe_to_mem_t exe_to_mem_i,
    output logic        stall_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic        dmem_req_we_o,
    output logic [31:0] dmem_req_addr_o,
    output logic [3:0]  dmem_req_be_o,
    output logic [31:0] dmem_req_wdata_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rsp_rdata_i,
    output mem_to_wb_t  mem_to_wb_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e      state_q, state_d;
    instr_t      instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_to_wb_t  wb_q, wb_d;

    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        trap_now;
    logic [15:0] lane;
    logic [31:0] load_data;

    // Capture-side address handling and store lane steering
    always_comb begin
        cap_addr = exe_to_mem_i.result;
`ifdef TARTARUGA_MEM_MISALIGN_TRAP_EN
        trap_now = ((exe_to_mem_i.instr.mem_size == SIZE_H) && exe_to_mem_i.result[0]) ||
                   ((exe_to_mem_i.instr.mem_size == SIZE_W) && (exe_to_mem_i.result[1:0] != 2'b00));
`else
        trap_now = 1'b0;
        case (exe_to_mem_i.instr.mem_size)
            SIZE_H:  cap_addr[0]   = 1'b0;
            SIZE_W:  cap_addr[1:0] = 2'b00;
            default: ;
        endcase
`endif
        case (exe_to_mem_i.instr.mem_size)
            SIZE_B: begin
                cap_be    = 4'b0001 << cap_addr[1:0];
                cap_wdata = {4{exe_to_mem_i.data_rs2[7:0]}};
            end
            SIZE_H: begin
                cap_be    = 4'b0011 << cap_addr[1:0];
                cap_wdata = {2{exe_to_mem_i.data_rs2[15:0]}};
            end
            default: begin
                cap_be    = 4'b1111;
                cap_wdata = exe_to_mem_i.data_rs2;
            end
        endcase
        if (exe_to_mem_i.instr.mem_kind != MEM_STORE) begin
            cap_be = 4'b0000;
        end
    end

    always_comb begin
        lane = 16'(dmem_rsp_rdata_i >> {addr_q[1:0], 3'b000});
        case (instr_q.mem_size)
            SIZE_B:  load_data = instr_q.mem_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SIZE_H:  load_data = instr_q.mem_unsigned ? {16'h0, lane} : {{16{lane[15]}}, lane};
            default: load_data = dmem_rsp_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        wb_d    = '0;
        case (state_q)
            IDLE: begin
                if (exe_to_mem_i.valid) begin
                    if ((exe_to_mem_i.instr.mem_kind == MEM_LOAD) ||
                        (exe_to_mem_i.instr.mem_kind == MEM_STORE)) begin
                        if (trap_now) begin
                            wb_d.valid  = 1'b1;
                            wb_d.instr  = exe_to_mem_i.instr;
                            wb_d.result = exe_to_mem_i.result;
                            wb_d.xcpt   = 1'b1;
                        end else begin
                            instr_d = exe_to_mem_i.instr;
                            addr_d  = cap_addr;
                            be_d    = cap_be;
                            wdata_d = cap_wdata;
                            state_d = REQ;
                        end
                    end else begin
                        wb_d.valid        = 1'b1;
                        wb_d.instr        = exe_to_mem_i.instr;
                        wb_d.result       = exe_to_mem_i.result;
                        wb_d.branch_taken = exe_to_mem_i.branch_taken;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready_i) begin
                    if (instr_q.mem_kind == MEM_STORE) begin
                        wb_d.valid  = 1'b1;
                        wb_d.instr  = instr_q;
                        wb_d.result = addr_q;
                        state_d     = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response arriving on the expiry cycle still completes the load
                if (dmem_rsp_valid_i) begin
                    wb_d.valid  = 1'b1;
                    wb_d.instr  = instr_q;
                    wb_d.result = load_data;
                    state_d     = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 1)) begin
                    wb_d.valid = 1'b1;
                    wb_d.instr = instr_q;
                    wb_d.xcpt  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_q <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            instr_q <= instr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign stall_o          = (state_q != IDLE);
    assign dmem_req_valid_o = (state_q == REQ);
    assign dmem_req_we_o    = dmem_req_valid_o && (instr_q.mem_kind == MEM_STORE);
    assign dmem_req_addr_o  = dmem_req_valid_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem_req_be_o    = dmem_req_valid_o ? be_q : 4'b0000;
    assign dmem_req_wdata_o = dmem_req_valid_o ? wdata_q : 32'h0;
    assign mem_to_wb_o      = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT_CYCLES=8; checks pass-through, stores, loads, stall, timeout, reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    exe_to_mem_t exe;
    logic        stall_o;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    mem_to_wb_t  wb;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .exe_to_mem_i     (exe),
        .stall_o          (stall_o),
        .dmem_req_valid_o (req_valid),
        .dmem_req_ready_i (req_ready),
        .dmem_req_we_o    (req_we),
        .dmem_req_addr_o  (req_addr),
        .dmem_req_be_o    (req_be),
        .dmem_req_wdata_o (req_wdata),
        .dmem_rsp_valid_i (rsp_valid),
        .dmem_rsp_rdata_i (rsp_rdata),
        .mem_to_wb_o      (wb)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input mem_kind_e kind, input mem_size_e size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rs2);
        exe.valid              = 1'b1;
        exe.instr.mem_kind     = kind;
        exe.instr.mem_size     = size;
        exe.instr.mem_unsigned = uns;
        exe.instr.addr_rd      = 5'd3;
        exe.result             = addr;
        exe.data_rs2           = rs2;
        exe.branch_taken       = 1'b0;
    endtask

    // Issue a load with ready=1, respond after `gap` idle WAIT cycles, check the written-back value
    task automatic do_load(input string tag, input mem_size_e size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr, input logic [31:0] exp_res);
        drive(MEM_LOAD, size, uns, addr, 32'h0);
        req_ready = 1'b1;
        tick();
        exe.valid = 1'b0;
        chk({tag, "_req_addr"}, req_addr, exp_addr);
        chk({tag, "_req_be"}, {28'h0, req_be}, 32'h0);
        // Response on the handshake cycle must be ignored
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1111_1111;
        tick();
        rsp_valid = 1'b0;
        chk({tag, "_wait_stall"}, {31'h0, stall_o}, 32'h1);
        tick();
        chk({tag, "_wait_novld"}, {31'h0, wb.valid}, 32'h0);
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        tick();
        rsp_valid = 1'b0;
        chk({tag, "_vld"}, {31'h0, wb.valid}, 32'h1);
        chk({tag, "_res"}, wb.result, exp_res);
        chk({tag, "_xcpt"}, {31'h0, wb.xcpt}, 32'h0);
    endtask

    initial begin
        rstn_i    = 1'b0;
        exe       = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        #12;
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_req_vld", {31'h0, req_valid}, 32'h0);
        chk("rst_wb_vld", {31'h0, wb.valid}, 32'h0);
        chk("rst_wb_xcpt", {31'h0, wb.xcpt}, 32'h0);
        chk("rst_req_fields", {req_addr[27:0], req_be}, 32'h0);
        chk("rst_wdata", req_wdata, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();

        // ALU op passes straight through
        drive(MEM_NONE, SIZE_W, 1'b0, 32'h0000_1234, 32'h0);
        exe.branch_taken = 1'b1;
        chk("add_stall", {31'h0, stall_o}, 32'h0);
        tick();
        exe.valid = 1'b0;
        chk("add_vld", {31'h0, wb.valid}, 32'h1);
        chk("add_res", wb.result, 32'h0000_1234);
        chk("add_br", {31'h0, wb.branch_taken}, 32'h1);
        chk("add_noreq", {31'h0, req_valid}, 32'h0);
        tick();
        chk("add_pulse", {31'h0, wb.valid}, 32'h0);

        // SB to byte lane 3
        drive(MEM_STORE, SIZE_B, 1'b0, 32'h0000_0103, 32'hAABB_CCDD);
        req_ready = 1'b1;
        tick();
        exe.valid = 1'b0;
        chk("sb_req_vld", {31'h0, req_valid}, 32'h1);
        chk("sb_we", {31'h0, req_we}, 32'h1);
        chk("sb_addr", req_addr, 32'h0000_0100);
        chk("sb_be", {28'h0, req_be}, 32'h8);
        chk("sb_wdata", req_wdata, 32'hDDDD_DDDD);
        chk("sb_wb_early", {31'h0, wb.valid}, 32'h0);
        tick();
        chk("sb_wb_vld", {31'h0, wb.valid}, 32'h1);
        chk("sb_wb_res", wb.result, 32'h0000_0103);
        chk("sb_stall_clr", {31'h0, stall_o}, 32'h0);

        // SH to upper half
        drive(MEM_STORE, SIZE_H, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
        tick();
        exe.valid = 1'b0;
        chk("sh_be", {28'h0, req_be}, 32'hC);
        chk("sh_wdata", req_wdata, 32'hABCD_ABCD);
        tick();

        // Sign- and zero-extended byte loads
        do_load("lb", SIZE_B, 1'b0, 32'h0000_0102, 32'h0080_0000, 32'h0000_0100, 32'hFFFF_FF80);
        do_load("lbu", SIZE_B, 1'b1, 32'h0000_0102, 32'h0080_0000, 32'h0000_0100, 32'h0000_0080);

        // LW with memory not ready for 5 cycles; next instruction held upstream
        drive(MEM_LOAD, SIZE_W, 1'b0, 32'h0000_0200, 32'h0);
        req_ready = 1'b0;
        tick();
        drive(MEM_NONE, SIZE_W, 1'b0, 32'h0000_0055, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("lw_bp_stall", {31'h0, stall_o}, 32'h1);
            chk("lw_bp_addr", req_addr, 32'h0000_0200);
            tick();
        end
        req_ready = 1'b1;
        tick();
        chk("lw_bp_wait_stall", {31'h0, stall_o}, 32'h1);
        chk("lw_bp_no_add", {31'h0, wb.valid}, 32'h0);
        rsp_valid = 1'b1;
        rsp_rdata = 32'hCAFE_F00D;
        tick();
        rsp_valid = 1'b0;
        chk("lw_bp_res", wb.result, 32'hCAFE_F00D);
        chk("lw_bp_stall_clr", {31'h0, stall_o}, 32'h0);
        tick();
        exe.valid = 1'b0;
        chk("held_add_vld", {31'h0, wb.valid}, 32'h1);
        chk("held_add_res", wb.result, 32'h0000_0055);
        tick();
        chk("held_add_once", {31'h0, wb.valid}, 32'h0);

        // Timeout after 8 WAIT cycles, late response ignored
        drive(MEM_LOAD, SIZE_W, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        exe.valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("to_pending", {31'h0, wb.valid}, 32'h0);
            tick();
        end
        tick();
        chk("to_vld", {31'h0, wb.valid}, 32'h1);
        chk("to_xcpt", {31'h0, wb.xcpt}, 32'h1);
        chk("to_res", wb.result, 32'h0);
        chk("to_stall_clr", {31'h0, stall_o}, 32'h0);
        rsp_valid = 1'b1;
        rsp_rdata = 32'h5555_5555;
        tick();
        rsp_valid = 1'b0;
        chk("to_late_rsp", {31'h0, wb.valid}, 32'h0);

        // Response on the expiry cycle wins over the timeout
        drive(MEM_LOAD, SIZE_W, 1'b0, 32'h0000_0304, 32'h0);
        tick();
        exe.valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678;
        tick();
        rsp_valid = 1'b0;
        chk("race_vld", {31'h0, wb.valid}, 32'h1);
        chk("race_xcpt", {31'h0, wb.xcpt}, 32'h0);
        chk("race_res", wb.result, 32'h1234_5678);

        // Misaligned halfword load
`ifdef TARTARUGA_MEM_MISALIGN_TRAP_EN
        drive(MEM_LOAD, SIZE_H, 1'b0, 32'h0000_0101, 32'h0);
        tick();
        exe.valid = 1'b0;
        chk("mis_noreq", {31'h0, req_valid}, 32'h0);
        chk("mis_stall", {31'h0, stall_o}, 32'h0);
        chk("mis_vld", {31'h0, wb.valid}, 32'h1);
        chk("mis_xcpt", {31'h0, wb.xcpt}, 32'h1);
        chk("mis_res", wb.result, 32'h0000_0101);
`else
        do_load("lh_mis", SIZE_H, 1'b0, 32'h0000_0101, 32'hA5B6_C7D8, 32'h0000_0100, 32'hFFFF_C7D8);
`endif

        // Reset in the middle of a request drops it immediately
        drive(MEM_LOAD, SIZE_W, 1'b0, 32'h0000_0400, 32'h0);
        req_ready = 1'b0;
        tick();
        exe.valid = 1'b0;
        chk("mid_req_vld", {31'h0, req_valid}, 32'h1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, req_valid}, 32'h0);
        chk("mid_rst_stall", {31'h0, stall_o}, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h7777_7777;
        tick();
        rsp_valid = 1'b0;
        chk("mid_rst_rsp_ign", {31'h0, wb.valid}, 32'h0);
        tick();
        chk("mid_rst_idle", {31'h0, stall_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
